// File: rtl/move_sequencer_if.sv
// move_sequencer_if
//   Groups the two handshake buses of the move sequencer:
//   - command push bus : cmd_valid, cmd_ndegs, cmd_ready
//   - driver bus       : step_enable, step_ndegs (launch), step_busy (driver motor_en)
//   Modports:
//   - slave  : the sequencer (accepts commands, drives the motor driver)
//   - master : the surroundings (command source plus motor driver)
interface move_sequencer_if;
    logic        cmd_valid;
    logic [15:0] cmd_ndegs;
    logic        cmd_ready;
    logic        step_enable;
    logic [15:0] step_ndegs;
    logic        step_busy;

    modport slave (
        input  cmd_valid,
        input  cmd_ndegs,
        output cmd_ready,
        output step_enable,
        output step_ndegs,
        input  step_busy
    );

    modport master (
        output cmd_valid,
        output cmd_ndegs,
        input  cmd_ready,
        input  step_enable,
        input  step_ndegs,
        output step_busy
    );
endinterface

// File: rtl/move_sequencer.sv
// move_sequencer
//   Command queue and launcher placed in front of a degree-stepping motor driver.
//   Rotation amounts are buffered in a circular FIFO. Each one is launched by
//   raising step_enable with step_ndegs held stable. The driver's busy flag then
//   tracks the move until it completes. A programmable dwell separates
//   consecutive moves. A driver that never starts raises a sticky fault.
//
//   Ports:
//     clk          16 MHz system clock
//     reset_n      asynchronous active-low reset
//     bus          command push bus and driver bus (slave side)
//     abort        level-sensitive flush of the queue; clears the fault
//     move_done    one-cycle pulse when a move completes
//     moves_done   completed-move counter, wraps modulo 2^16
//     queue_level  number of queued entries
//     seq_idle     sequencer idle and queue empty
//     fault        sticky start-timeout flag
module move_sequencer #(
    parameter int DEPTH         = 8,      // power of two, >= 2
    parameter int DWELL_CYCLES  = 16000,  // 0 disables the dwell
    parameter int START_TIMEOUT = 16      // >= 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    move_sequencer_if.slave        bus,
    input  logic                   abort,
    output logic                   move_done,
    output logic [15:0]            moves_done,
    output logic [$clog2(DEPTH):0] queue_level,
    output logic                   seq_idle,
    output logic                   fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(START_TIMEOUT);
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    // Terminal counts. Both counters stop at these values, so they never wrap.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [DW-1:0] DWELL_LAST   = DW'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);
    localparam logic [AW:0]   FULL_LEVEL   = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DWELL,
        S_FAULT
    } state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [TW-1:0] timeout_cnt;
    logic [DW-1:0] dwell_cnt;
    logic          push;
    logic          pop;

    // A fault or an abort refuses pushes, so nothing sneaks into a queue
    // that is being flushed.
    assign bus.cmd_ready = (queue_level != FULL_LEVEL) && !abort && !fault;
    assign push          = bus.cmd_valid && bus.cmd_ready;

    // The head is consumed only from IDLE. A freshly written entry reaches the
    // state machine one cycle later through queue_level (no bypass path).
    assign pop      = (state == S_IDLE) && (queue_level != '0) && !abort;
    assign seq_idle = (state == S_IDLE) && (queue_level == '0);

    // NOTE: the storage array has no reset. An entry is read only after it has
    // been written, and queue_level guards every read, so clearing it would add
    // reset fan-out and buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.cmd_ndegs;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. The separate
    // level counter distinguishes full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_level <= '0;
        end else if (abort) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                queue_level <= queue_level + 1'b1;
            end else if (pop && !push) begin
                queue_level <= queue_level - 1'b1;
            end
        end
    end

    // NOTE: every register here uses non-blocking assignment, so all branches
    // see the pre-edge values of state and the counters regardless of
    // statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            bus.step_enable <= 1'b0;
            bus.step_ndegs  <= '0;
            move_done       <= 1'b0;
            moves_done      <= '0;
            fault           <= 1'b0;
            timeout_cnt     <= '0;
            dwell_cnt       <= '0;
        end else begin
            move_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        bus.step_ndegs  <= mem[rd_ptr];
                        bus.step_enable <= 1'b1;
                        timeout_cnt     <= '0;
                        state           <= S_LAUNCH;
                    end
                end

                // The driver's start takes priority. Once it has started it
                // cannot be stopped, so even a concurrent abort must let the
                // move be tracked to completion in RUN.
                S_LAUNCH: begin
                    if (bus.step_busy) begin
                        bus.step_enable <= 1'b0;
                        state           <= S_RUN;
                    end else if (abort) begin
                        bus.step_enable <= 1'b0;
                        state           <= S_IDLE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        bus.step_enable <= 1'b0;
                        fault           <= 1'b1;
                        state           <= S_FAULT;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end

                // Abort is deliberately ignored here. Completion is the first
                // sample of busy low, which also covers a one-cycle busy pulse
                // from a zero-degree move.
                S_RUN: begin
                    if (!bus.step_busy) begin
                        move_done  <= 1'b1;
                        moves_done <= moves_done + 1'b1;
                        dwell_cnt  <= '0;
                        state      <= (DWELL_CYCLES == 0) ? S_IDLE : S_DWELL;
                    end
                end

                S_DWELL: begin
                    if (abort || (dwell_cnt == DWELL_LAST)) begin
                        state <= S_IDLE;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end

                S_FAULT: begin
                    if (abort) begin
                        fault <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer
//   Self-checking bench for move_sequencer (DEPTH 8, DWELL_CYCLES 5,
//   START_TIMEOUT 16). A behavioural motor driver answers step_enable and holds
//   busy for ndegs+1 cycles. A queue-based reference model predicts every
//   output and is compared each cycle. Directed scenarios add hand-computed
//   literal expectations.
`timescale 1ns/1ps
module tb_move_sequencer;
    localparam int DEPTH         = 8;
    localparam int DWELL_CYCLES  = 5;
    localparam int START_TIMEOUT = 16;

    logic        clk;
    logic        clk_run;
    logic        reset_n;
    logic        abort;
    logic        move_done;
    logic [15:0] moves_done;
    logic [3:0]  queue_level;
    logic        seq_idle;
    logic        fault;

    move_sequencer_if bus ();

    move_sequencer #(
        .DEPTH        (DEPTH),
        .DWELL_CYCLES (DWELL_CYCLES),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .abort      (abort),
        .move_done  (move_done),
        .moves_done (moves_done),
        .queue_level(queue_level),
        .seq_idle   (seq_idle),
        .fault      (fault)
    );

    // The clock can be frozen for the asynchronous reset check.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Motor driver model: starts on enable while idle, then stays busy for ndegs+1 cycles.
    logic [15:0] drv_left;
    logic        drv_stall;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.step_busy <= 1'b0;
            drv_left      <= '0;
        end else if (drv_stall) begin
            bus.step_busy <= 1'b0;
        end else if (bus.step_busy) begin
            if (drv_left == 16'd0) bus.step_busy <= 1'b0;
            else drv_left <= drv_left - 16'd1;
        end else if (bus.step_enable) begin
            bus.step_busy <= 1'b1;
            drv_left      <= bus.step_ndegs;
        end
    end

    // Reference model: flags and countdowns, advanced once per clock.
    logic [15:0] m_q[$];
    logic        m_launching;
    logic        m_moving;
    logic        m_fault;
    logic        m_done;
    logic [15:0] m_ndegs;
    logic [15:0] m_moves;
    int          m_wait;
    int          m_cool;

    task automatic model_reset();
        m_q.delete();
        m_launching = 0; m_moving = 0; m_fault = 0; m_done = 0;
        m_ndegs = 0; m_moves = 0; m_wait = 0; m_cool = 0;
    endtask

    // Called between edges with the inputs the next edge will sample.
    task automatic model_step();
        bit push_ok;
        push_ok = bus.cmd_valid && (m_q.size() != DEPTH) && !abort && !m_fault;
        m_done  = 1'b0;
        if (m_launching) begin
            if (bus.step_busy) begin
                m_launching = 0; m_moving = 1;
            end else if (abort) begin
                m_launching = 0;
            end else begin
                m_wait++;
                if (m_wait == START_TIMEOUT) begin
                    m_launching = 0; m_fault = 1;
                end
            end
        end else if (m_moving) begin
            if (!bus.step_busy) begin
                m_moving = 0; m_done = 1; m_moves = m_moves + 16'd1; m_cool = DWELL_CYCLES;
            end
        end else if (m_fault) begin
            if (abort) m_fault = 0;
        end else if (m_cool > 0) begin
            m_cool = abort ? 0 : m_cool - 1;
        end else if (m_q.size() != 0 && !abort) begin
            m_ndegs = m_q.pop_front(); m_launching = 1; m_wait = 0;
        end
        if (abort) m_q.delete();
        else if (push_ok) m_q.push_back(bus.cmd_ndegs);
    endtask

    // Monitor bookkeeping for the directed literal checks.
    int          cyc = 0;
    int          launches = 0;
    int          done_pulses = 0;
    int          done_cyc = 0;
    int          en_len = 0;
    int          last_en_len = 0;
    logic        en_prev = 1'b0;
    logic [15:0] launch_vals[$];
    int          gaps[$];

    // Single compare process: half a cycle plus 1 ns after each rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!reset_n) begin
                model_reset();
            end else begin
                if (bus.step_enable) begin
                    if (!en_prev) begin
                        launches++;
                        launch_vals.push_back(bus.step_ndegs);
                        gaps.push_back(cyc - done_cyc);
                    end
                    en_len++;
                end else if (en_prev) begin
                    last_en_len = en_len;
                    en_len = 0;
                end
                en_prev = bus.step_enable;
                if (move_done) begin
                    done_pulses++;
                    done_cyc = cyc;
                end

                check("step_enable", bus.step_enable, m_launching);
                check("step_ndegs", bus.step_ndegs, m_ndegs);
                check("move_done", move_done, m_done);
                check("moves_done", moves_done, m_moves);
                check("queue_level", queue_level, m_q.size());
                check("fault", fault, m_fault);
                check("seq_idle", seq_idle,
                      !m_launching && !m_moving && !m_fault && m_cool == 0 && m_q.size() == 0);
                check("cmd_ready", bus.cmd_ready, (m_q.size() != DEPTH) && !abort && !m_fault);
                model_step();
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push_cmd(input logic [15:0] v);
        bus.cmd_valid = 1'b1;
        bus.cmd_ndegs = v;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    int base_launch;
    int base_done;

    initial begin
        clk_run       = 1'b1;
        reset_n       = 1'b0;
        abort         = 1'b0;
        drv_stall     = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_ndegs = '0;
        repeat (3) @(negedge clk);

        // Reset values while reset is held.
        check("rst_step_enable", bus.step_enable, 0);
        check("rst_seq_idle", seq_idle, 1);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_queue_level", queue_level, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 90-degree move.
        push_cmd(16'd90);
        for (int i = 0; i < 300 && !move_done; i++) @(negedge clk);
        check("single_done_seen", move_done, 1);
        check("single_en_len", last_en_len, 2);
        check("single_moves", moves_done, 1);
        for (int i = 0; i < 20 && !seq_idle; i++) @(negedge clk);
        check("single_idle", seq_idle, 1);
        check("single_pulses", done_pulses, 1);

        // Back-to-back 10, 0, 20 with a 5-cycle dwell.
        launch_vals.delete();
        gaps.delete();
        done_pulses = 0;
        push_cmd(16'd10);
        push_cmd(16'd0);
        push_cmd(16'd20);
        for (int i = 0; i < 400 && done_pulses < 3; i++) @(negedge clk);
        for (int i = 0; i < 20 && !seq_idle; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("b2b_launches", launch_vals.size(), 3);
        check("b2b_ndegs0", launch_vals[0], 10);
        check("b2b_ndegs1", launch_vals[1], 0);
        check("b2b_ndegs2", launch_vals[2], 20);
        check("b2b_gap1", gaps[1], 6);
        check("b2b_gap2", gaps[2], 6);
        check("b2b_pulses", done_pulses, 3);
        check("b2b_moves", moves_done, 4);

        // Full FIFO: fill during a long move, ninth push dropped.
        push_cmd(16'd200);
        for (int i = 0; i < 10 && !bus.step_busy; i++) @(negedge clk);
        check("full_busy_seen", bus.step_busy, 1);
        for (int i = 0; i < 9; i++) push_cmd(16'(3 + i));
        check("full_level", queue_level, 8);
        check("full_ready", bus.cmd_ready, 0);
        for (int i = 0; i < 400 && queue_level != 4'd7; i++) @(negedge clk);
        check("full_pop_level", queue_level, 7);
        check("full_ready_back", bus.cmd_ready, 1);

        // Abort mid-RUN with entries still queued.
        for (int i = 0; i < 10 && !bus.step_busy; i++) @(negedge clk);
        check("abort_head", bus.step_ndegs, 3);
        @(negedge clk);
        base_launch = launches;
        base_done   = done_pulses;
        pulse_abort();
        check("abort_level", queue_level, 0);
        for (int i = 0; i < 20 && done_pulses == base_done; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        check("abort_one_done", done_pulses, base_done + 1);
        check("abort_no_launch", launches, base_launch);
        check("abort_moves", moves_done, 6);
        check("abort_idle", seq_idle, 1);

        // Start timeout with a driver that never answers.
        drv_stall = 1'b1;
        push_cmd(16'd45);
        push_cmd(16'd46);
        for (int i = 0; i < 100 && !fault; i++) @(negedge clk);
        check("to_fault", fault, 1);
        @(negedge clk);
        check("to_en_len", last_en_len, 16);
        check("to_enable_low", bus.step_enable, 0);
        check("to_level_held", queue_level, 1);
        push_cmd(16'd77);
        check("to_push_refused", queue_level, 1);
        pulse_abort();
        check("to_fault_clear", fault, 0);
        check("to_level_flush", queue_level, 0);
        drv_stall = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-RUN with the clock frozen.
        push_cmd(16'd100);
        push_cmd(16'd101);
        for (int i = 0; i < 10 && !bus.step_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("pre_rst_ndegs", bus.step_ndegs, 100);
        check("pre_rst_level", queue_level, 1);
        clk_run = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_enable", bus.step_enable, 0);
        check("arst_ndegs", bus.step_ndegs, 0);
        check("arst_move_done", move_done, 0);
        check("arst_moves", moves_done, 0);
        check("arst_level", queue_level, 0);
        check("arst_fault", fault, 0);
        check("arst_idle", seq_idle, 1);
        check("arst_ready", bus.cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
